// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl
//   Run/step/halt sequencer for the program counter. Turns host debug
//   commands, a decoded HALT instruction and one PC-match breakpoint into
//   the PC block's advance enable and synchronous reset. It also counts
//   the retired instructions, which are the cycles where the PC advanced.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   cmd_start    pulse: free-run
//   cmd_stop     pulse: halt
//   cmd_step     pulse: advance exactly one instruction
//   cmd_reset    pulse: reset the processor PC (RST_CYCLES cycles)
//   halt_insn    instruction at pc_i decodes as HALT
//   bp_en        breakpoint enable
//   bp_addr      breakpoint PC (full 32-bit compare)
//   pc_i         current PC
//   proc_run_en  PC advance enable (combinational, same-cycle stop)
//   proc_reset   PC synchronous reset, active high
//   state_o      state register
//   halted_o     high in HALT
//   busy_o       high in RST_SEQ, RUN, STEP
//   retired_cnt  saturating count of cycles with proc_run_en=1
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE  0 | out of reset or reset sequence finished, PC held
// RST_SEQ1| proc_reset asserted, rst_cnt counting down to 0
// RUN   2 | free-running until stop, breakpoint or HALT instruction
// STEP  3 | single advance, then HALT
// HALT  4 | stopped by the debugger, a breakpoint or a HALT instruction
module proc_run_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_start,
    input  logic             cmd_stop,
    input  logic             cmd_step,
    input  logic             cmd_reset,
    input  logic             halt_insn,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc_i,
    output logic             proc_run_en,
    output logic             proc_reset,
    output logic [2:0]       state_o,
    output logic             halted_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RST_LOAD = RC_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST_SEQ = 3'd1,
        S_RUN     = 3'd2,
        S_STEP    = 3'd3,
        S_HALT    = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [RC_W-1:0] rst_cnt;
    logic [RC_W-1:0] rst_cnt_nxt;
    logic            resume_mask;
    logic            resume_mask_nxt;
    logic            run_stop;

    // The breakpoint and HALT-instruction terms are masked during the first
    // RUN cycle. Without the mask, start would be a no-op while the PC sits
    // on the address that stopped it.
    assign run_stop = cmd_stop ||
                      (((bp_en && (pc_i == bp_addr)) || halt_insn) && !resume_mask);

    always_comb begin
        state_nxt       = state;
        rst_cnt_nxt     = rst_cnt;
        resume_mask_nxt = resume_mask;
        proc_run_en     = 1'b0;
        case (state)
            S_IDLE, S_HALT: begin
                // Command priority is stop > step > start. A stop from
                // IDLE or HALT has no effect, but it still drops the
                // commands below it.
                if (cmd_stop) begin
                    state_nxt = state;
                end else if (cmd_step) begin
                    state_nxt = S_STEP;
                end else if (cmd_start) begin
                    state_nxt       = S_RUN;
                    resume_mask_nxt = 1'b1;
                end
            end
            S_RST_SEQ: begin
                if (rst_cnt == '0) state_nxt = S_IDLE;
                else               rst_cnt_nxt = rst_cnt - 1'b1;
            end
            S_RUN: begin
                proc_run_en     = !run_stop;
                resume_mask_nxt = 1'b0;
                if (run_stop) state_nxt = S_HALT;
            end
            S_STEP: begin
                proc_run_en = !cmd_stop;
                state_nxt   = S_HALT;
            end
            default: begin
                state_nxt       = S_IDLE;
                resume_mask_nxt = 1'b0;
            end
        endcase
        if (cmd_reset) begin
            state_nxt       = S_RST_SEQ;
            rst_cnt_nxt     = RST_LOAD;
            resume_mask_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            rst_cnt     <= '0;
            resume_mask <= 1'b0;
            proc_reset  <= 1'b0;
            halted_o    <= 1'b0;
            busy_o      <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state       <= state_nxt;
            rst_cnt     <= rst_cnt_nxt;
            resume_mask <= resume_mask_nxt;
            // Flags are decoded from the next state, so they stay aligned
            // with the state register without adding decode glitches.
            proc_reset  <= (state_nxt == S_RST_SEQ);
            halted_o    <= (state_nxt == S_HALT);
            busy_o      <= (state_nxt == S_RST_SEQ) || (state_nxt == S_RUN) ||
                           (state_nxt == S_STEP);
            if (cmd_reset)
                retired_cnt <= '0;
            else if (proc_run_en && (retired_cnt != '1))
                retired_cnt <= retired_cnt + 1'b1;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_proc_run_ctrl.sv
module tb_proc_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_start = 1'b0, cmd_stop = 1'b0, cmd_step = 1'b0, cmd_reset = 1'b0;
    logic        halt_insn;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'h0;
    logic [31:0] pc = 32'h0;
    logic        proc_run_en, proc_reset, halted_o, busy_o;
    logic [2:0]  state_o;
    logic [31:0] retired_cnt;

    logic        halt_en = 1'b0;
    logic [31:0] halt_pc = 32'h0;

    logic        s_cmd_start = 1'b0, s_cmd_stop = 1'b0;
    logic        s_run_en, s_proc_reset, s_halted, s_busy;
    logic [2:0]  s_state;
    logic [3:0]  s_retired;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Model of the PC block: holds on async reset, zeroes on proc_reset.
    always_ff @(posedge clk) begin
        if (proc_reset)       pc <= 32'h0;
        else if (proc_run_en) pc <= pc + 32'h4;
    end

    assign halt_insn = halt_en && (pc == halt_pc);

    proc_run_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_step(cmd_step), .cmd_reset(cmd_reset),
        .halt_insn(halt_insn), .bp_en(bp_en), .bp_addr(bp_addr), .pc_i(pc),
        .proc_run_en(proc_run_en), .proc_reset(proc_reset), .state_o(state_o),
        .halted_o(halted_o), .busy_o(busy_o), .retired_cnt(retired_cnt)
    );

    proc_run_ctrl #(.RST_CYCLES(4), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .cmd_start(s_cmd_start), .cmd_stop(s_cmd_stop), .cmd_step(1'b0), .cmd_reset(1'b0),
        .halt_insn(1'b0), .bp_en(1'b0), .bp_addr(32'h0), .pc_i(32'h0),
        .proc_run_en(s_run_en), .proc_reset(s_proc_reset), .state_o(s_state),
        .halted_o(s_halted), .busy_o(s_busy), .retired_cnt(s_retired)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        int n;
        cmd_reset = 1'b1;
        tick();
        cmd_reset = 1'b0;
        n = 0;
        while (state_o !== 3'd0 && n < 20) begin
            tick();
            n++;
        end
        if (state_o !== 3'd0) begin
            n_vec++; n_err++;
            $display("FAIL do_reset_timeout: state=%0d required 0", state_o);
        end
    endtask

    task automatic test_reset();
        int n;
        #2;
        n_vec++;
        if ({proc_run_en, proc_reset, halted_o, busy_o, state_o} !== 7'b0) begin
            n_err++;
            $display("FAIL rst_outputs: run_en=%b reset=%b halted=%b busy=%b state=%0d required all 0",
                     proc_run_en, proc_reset, halted_o, busy_o, state_o);
        end
        n_vec++;
        if (retired_cnt !== 32'h0) begin
            n_err++; $display("FAIL rst_retired: got %0d required 0", retired_cnt);
        end
        tick();
        rst = 1'b1;
        tick();
        cmd_reset = 1'b1;
        tick();
        cmd_reset = 1'b0;
        n = 0;
        while (proc_reset === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        n_vec++;
        if (n !== 4) begin
            n_err++; $display("FAIL rst_seq_len: got %0d cycles required 4", n);
        end
        n_vec++;
        if (state_o !== 3'd0) begin
            n_err++; $display("FAIL rst_seq_end_state: got %0d required 0", state_o);
        end
        n_vec++;
        if (retired_cnt !== 32'h0 || pc !== 32'h0) begin
            n_err++; $display("FAIL rst_seq_end_cnt_pc: cnt=%0d pc=%h required 0/0", retired_cnt, pc);
        end
    endtask

    task automatic test_free_run();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        n_vec++;
        if (state_o !== 3'd2 || proc_run_en !== 1'b1 || busy_o !== 1'b1) begin
            n_err++; $display("FAIL run_entry: state=%0d run_en=%b busy=%b required 2/1/1",
                              state_o, proc_run_en, busy_o);
        end
        repeat (10) tick();
        cmd_stop = 1'b1;
        #1;
        n_vec++;
        if (proc_run_en !== 1'b0) begin
            n_err++; $display("FAIL run_stop_cycle_en: got %b required 0", proc_run_en);
        end
        tick();
        cmd_stop = 1'b0;
        n_vec++;
        if (pc !== 32'h28 || retired_cnt !== 32'd10) begin
            n_err++; $display("FAIL run_stop_pc_cnt: pc=%h cnt=%0d required 28/10", pc, retired_cnt);
        end
        n_vec++;
        if (state_o !== 3'd4 || halted_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL run_stop_state: state=%0d halted=%b busy=%b required 4/1/0",
                              state_o, halted_o, busy_o);
        end
    endtask

    task automatic test_breakpoint();
        do_reset();
        bp_en = 1'b1;
        bp_addr = 32'h10;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        repeat (4) tick();
        n_vec++;
        if (pc !== 32'h10 || proc_run_en !== 1'b0 || state_o !== 3'd2) begin
            n_err++; $display("FAIL bp_hit_cycle: pc=%h run_en=%b state=%0d required 10/0/2",
                              pc, proc_run_en, state_o);
        end
        tick();
        n_vec++;
        if (pc !== 32'h10 || retired_cnt !== 32'd4 || state_o !== 3'd4) begin
            n_err++; $display("FAIL bp_halt: pc=%h cnt=%0d state=%0d required 10/4/4",
                              pc, retired_cnt, state_o);
        end
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        n_vec++;
        if (proc_run_en !== 1'b1) begin
            n_err++; $display("FAIL bp_resume_en: got %b required 1", proc_run_en);
        end
        tick();
        n_vec++;
        if (pc !== 32'h14 || retired_cnt !== 32'd5) begin
            n_err++; $display("FAIL bp_resume_pc: pc=%h cnt=%0d required 14/5", pc, retired_cnt);
        end
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        bp_en = 1'b0;
    endtask

    task automatic test_step();
        for (int k = 1; k <= 3; k++) begin
            cmd_step = 1'b1;
            #1;
            n_vec++;
            if (proc_run_en !== 1'b0) begin
                n_err++; $display("FAIL step_%0d_pre_en: got %b required 0", k, proc_run_en);
            end
            tick();
            cmd_step = 1'b0;
            n_vec++;
            if (state_o !== 3'd3 || proc_run_en !== 1'b1) begin
                n_err++; $display("FAIL step_%0d_active: state=%0d run_en=%b required 3/1",
                                  k, state_o, proc_run_en);
            end
            tick();
            tick();
            tick();
            n_vec++;
            if (pc !== 32'h14 + 32'(4 * k) || retired_cnt !== 32'(5 + k) || state_o !== 3'd4) begin
                n_err++; $display("FAIL step_%0d_result: pc=%h cnt=%0d state=%0d required %h/%0d/4",
                                  k, pc, retired_cnt, state_o, 32'h14 + 32'(4 * k), 5 + k);
            end
        end
    endtask

    task automatic test_halt_insn();
        do_reset();
        halt_en = 1'b1;
        halt_pc = 32'h20;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        repeat (8) tick();
        n_vec++;
        if (pc !== 32'h20 || proc_run_en !== 1'b0) begin
            n_err++; $display("FAIL halt_insn_cycle: pc=%h run_en=%b required 20/0", pc, proc_run_en);
        end
        tick();
        tick();
        n_vec++;
        if (pc !== 32'h20 || halted_o !== 1'b1 || retired_cnt !== 32'd8) begin
            n_err++; $display("FAIL halt_insn_hold: pc=%h halted=%b cnt=%0d required 20/1/8",
                              pc, halted_o, retired_cnt);
        end
        cmd_reset = 1'b1;
        cmd_start = 1'b1;
        tick();
        cmd_reset = 1'b0;
        cmd_start = 1'b0;
        n_vec++;
        if (state_o !== 3'd1 || proc_reset !== 1'b1 || retired_cnt !== 32'd0) begin
            n_err++; $display("FAIL reset_beats_start: state=%0d reset=%b cnt=%0d required 1/1/0",
                              state_o, proc_reset, retired_cnt);
        end
        halt_en = 1'b0;
        repeat (5) tick();
        n_vec++;
        if (state_o !== 3'd0) begin
            n_err++; $display("FAIL reset_beats_start_end: state=%0d required 0", state_o);
        end
    endtask

    task automatic test_priority();
        int n;
        cmd_stop = 1'b1;
        cmd_step = 1'b1;
        tick();
        cmd_stop = 1'b0;
        cmd_step = 1'b0;
        n_vec++;
        if (state_o !== 3'd0) begin
            n_err++; $display("FAIL prio_stop_over_step: state=%0d required 0", state_o);
        end
        cmd_step = 1'b1;
        cmd_start = 1'b1;
        tick();
        cmd_step = 1'b0;
        cmd_start = 1'b0;
        n_vec++;
        if (state_o !== 3'd3) begin
            n_err++; $display("FAIL prio_step_over_start: state=%0d required 3", state_o);
        end
        tick();
        // Reset reload: two high cycles, then a second reset restarts the count.
        cmd_reset = 1'b1;
        tick();
        cmd_reset = 1'b0;
        tick();
        cmd_reset = 1'b1;
        cmd_start = 1'b1;
        tick();
        cmd_reset = 1'b0;
        cmd_start = 1'b0;
        n = 0;
        while (proc_reset === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        n_vec++;
        if (n !== 4 || state_o !== 3'd0) begin
            n_err++; $display("FAIL rst_reload: tail=%0d state=%0d required 4/0", n, state_o);
        end
    endtask

    task automatic test_async_reset();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (proc_run_en !== 1'b1 || pc !== 32'hC) begin
            n_err++; $display("FAIL async_pre: run_en=%b pc=%h required 1/c", proc_run_en, pc);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if ({proc_run_en, proc_reset, halted_o, busy_o, state_o} !== 7'b0 || retired_cnt !== 32'h0) begin
            n_err++; $display("FAIL async_outputs: run_en=%b reset=%b halted=%b busy=%b state=%0d cnt=%0d required all 0",
                              proc_run_en, proc_reset, halted_o, busy_o, state_o, retired_cnt);
        end
        tick();
        n_vec++;
        if (pc !== 32'hC) begin
            n_err++; $display("FAIL async_pc_hold: pc=%h required c", pc);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        s_cmd_start = 1'b1;
        tick();
        s_cmd_start = 1'b0;
        repeat (14) tick();
        n_vec++;
        if (s_retired !== 4'd14) begin
            n_err++; $display("FAIL sat_14: got %0d required 14", s_retired);
        end
        tick();
        n_vec++;
        if (s_retired !== 4'd15) begin
            n_err++; $display("FAIL sat_15: got %0d required 15", s_retired);
        end
        repeat (6) tick();
        n_vec++;
        if (s_retired !== 4'd15 || s_run_en !== 1'b1) begin
            n_err++; $display("FAIL sat_hold: cnt=%0d run_en=%b required 15/1", s_retired, s_run_en);
        end
        s_cmd_stop = 1'b1;
        tick();
        s_cmd_stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_breakpoint();
        test_step();
        test_halt_insn();
        test_priority();
        test_async_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
